// File: rtl/timer_ctrl.sv
// timer_ctrl: run/pause/clear sequencer for the 16-bit tenth-of-second timer.
// Owns the tick prescaler and the elapsed count. Count updates, and lap
// captures when built in, are published through a single valid/ready output
// register. A newer value always replaces an unconsumed one, and the sticky
// ovr flag records that this happened.
//
// Optional feature macro: TIMER_CTRL_LAP_EN (lap capture). When it is not
// defined, lap_btn is ignored and out_is_lap is tied 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_btn       start/resume (rising edge)
//   stop_btn        pause (rising edge)
//   clr_btn         clear to IDLE (rising edge)
//   lap_btn         lap capture (rising edge, lap build only)
//   out_ready       consumer accepts out_data this cycle
//   out_valid       out_data holds an unconsumed value
//   out_data[15:0]  count value (update or lap)
//   out_is_lap      out_data is a lap capture
//   running         high in RUN
//   state[1:0]      00 IDLE, 01 RUN, 10 PAUSE
//   ovr             sticky: unconsumed value was overwritten
module timer_ctrl #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        clr_btn,
  input  logic        lap_btn,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_is_lap,
  output logic        running,
  output logic [1:0]  state,
  output logic        ovr
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [31:0] PRESC_MAX = 32'(TICK_DIV - 1);

  state_t      cur, nxt;
  logic [31:0] presc;
  logic [15:0] count;
  logic        start_d, stop_d, clr_d;
  logic        start_rise, stop_rise, clr_rise;
  logic        tick, lap_evt, evt;
  logic [15:0] evt_data;

  // Button edge registers; they reset to 0, so a button that is held through
  // reset release is seen as a rise on the first clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d <= 1'b0;
      stop_d  <= 1'b0;
      clr_d   <= 1'b0;
    end else begin
      start_d <= start_btn;
      stop_d  <= stop_btn;
      clr_d   <= clr_btn;
    end
  end

  assign start_rise = start_btn & ~start_d;
  assign stop_rise  = stop_btn  & ~stop_d;
  assign clr_rise   = clr_btn   & ~clr_d;

`ifdef TIMER_CTRL_LAP_EN
  logic lap_d, lap_rise, lap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_d <= 1'b0;
    else     lap_d <= lap_btn;
  end

  assign lap_rise = lap_btn & ~lap_d;
  // A lap acts only when no higher-priority rise applies in this state.
  // In RUN that is stop. In PAUSE that is start. clr applies in every state.
  assign lap_evt  = lap_rise & ~clr_rise &
                    (((cur == RUN)   & ~stop_rise) |
                     ((cur == PAUSE) & ~start_rise));
`else
  logic unused_lap;
  assign unused_lap = lap_btn;
  assign lap_evt    = 1'b0;
`endif

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (clr_rise) nxt = IDLE;
    else begin
      case (cur)
        IDLE:    if (start_rise) nxt = RUN;
        RUN:     if (stop_rise)  nxt = PAUSE;
        PAUSE:   if (start_rise) nxt = RUN;
        default: nxt = IDLE;
      endcase
    end
  end

  assign state   = cur;
  assign running = (cur == RUN);

  // The prescaler advances on every edge taken in RUN, including the edge
  // that moves the FSM to PAUSE. It holds in PAUSE, so partial tick time is
  // kept across a pause.
  assign tick = (cur == RUN) && (presc == PRESC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      count <= '0;
    end else begin
      if (clr_rise)                        presc <= '0;
      else if (cur == IDLE && start_rise)  presc <= '0;
      else if (cur == RUN)                 presc <= tick ? '0 : presc + 32'd1;

      if (clr_rise)  count <= '0;
      else if (tick) count <= count + 16'd1;
    end
  end

  // A lap takes priority over a coincident tick and captures the count
  // before it increments. The tick's update is dropped in that case.
  assign evt      = ~clr_rise & (tick | lap_evt);
  assign evt_data = lap_evt ? count : count + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ovr       <= 1'b0;
    end else if (clr_rise) begin
      out_valid <= 1'b0;
      ovr       <= 1'b0;
    end else if (evt) begin
      out_valid <= 1'b1;
      out_data  <= evt_data;
      if (out_valid & ~out_ready) ovr <= 1'b1;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef TIMER_CTRL_LAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           lap_q <= 1'b0;
    else if (clr_rise) lap_q <= 1'b0;
    else if (evt)      lap_q <= lap_evt;
  end
  assign out_is_lap = lap_q;
`else
  assign out_is_lap = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=4. Inputs change 1 time unit
// after a rising edge. Outputs are sampled at that same point.
module tb_timer_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn, stop_btn, clr_btn, lap_btn, out_ready;
  logic        out_valid, out_is_lap, running, ovr;
  logic [15:0] out_data;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_pass = 0;

  timer_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .start_btn(start_btn), .stop_btn(stop_btn), .clr_btn(clr_btn),
    .lap_btn(lap_btn), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_is_lap(out_is_lap),
    .running(running), .state(state), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Checks a published value: valid=1 with the given data and lap flag.
  task automatic chk_out(input string tag, input logic [15:0] d, input logic lap);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".lap"},   32'(out_is_lap), 32'(lap));
  endtask

  task automatic pulse_clr();
    clr_btn = 1'b1; step(1); clr_btn = 1'b0;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1; step(1); start_btn = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_btn = 1'b0; stop_btn = 1'b0; clr_btn = 1'b0; lap_btn = 1'b0;
    out_ready = 1'b1;
    step(2);
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.running", 32'(running), 32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.lap", 32'(out_is_lap), 32'd0);
    chk("rst.ovr", 32'(ovr), 32'd0);
    rst = 1'b0;
    step(1);

    // Start: RUN after the sampling edge, then ticks every 4 cycles.
    pulse_start();
    chk("a.running", 32'(running), 32'd1);
    chk("a.state", 32'(state), 32'd1);
    step(3);
    chk("a.pre_tick", 32'(out_valid), 32'd0);
    step(1);
    chk_out("a.t1", 16'd1, 1'b0);
    step(1);
    chk("a.consumed", 32'(out_valid), 32'd0);
    step(3);
    chk_out("a.t2", 16'd2, 1'b0);
    step(4);
    chk_out("a.t3", 16'd3, 1'b0);

    // Pause keeps partial prescaler time.
    pulse_clr();
    pulse_start();
    step(4);
    chk_out("b.t1", 16'd1, 1'b0);
    step(1);
    pulse_stop();                      // 6th edge in RUN, prescaler at 2
    chk("b.paused", 32'(state), 32'd2);
    chk("b.running", 32'(running), 32'd0);
    step(20);
    chk("b.hold", 32'(out_valid), 32'd0);
    pulse_start();
    chk("b.resumed", 32'(state), 32'd1);
    step(1);
    chk("b.early", 32'(out_valid), 32'd0);
    step(1);
    chk_out("b.t2", 16'd2, 1'b0);

    // Overwrite while stalled sets ovr. clr clears it.
    pulse_clr();
    pulse_start();
    out_ready = 1'b0;
    step(4);
    chk_out("c.t1", 16'd1, 1'b0);
    chk("c.ovr0", 32'(ovr), 32'd0);
    step(4);
    chk_out("c.t2", 16'd2, 1'b0);
    chk("c.ovr1", 32'(ovr), 32'd1);
    out_ready = 1'b1;
    step(1);
    chk("c.drained", 32'(out_valid), 32'd0);
    chk("c.ovr_sticky", 32'(ovr), 32'd1);
    pulse_clr();
    chk("c.clr_ovr", 32'(ovr), 32'd0);
    chk("c.clr_state", 32'(state), 32'd0);
    chk("c.clr_valid", 32'(out_valid), 32'd0);
    pulse_start();
    step(4);
    chk_out("c.count0", 16'd1, 1'b0);

    // Wrap: preload 0xFFFE while paused.
    pulse_stop();                      // prescaler 1
    force dut.count = 16'hFFFE;
    step(1);
    release dut.count;
    pulse_start();
    step(3);
    chk_out("d.ffff", 16'hFFFF, 1'b0);
    step(4);
    chk_out("d.wrap", 16'h0000, 1'b0);

    // Lap on the same edge as the 5->6 tick, then lap while paused.
    pulse_clr();
    pulse_start();
    step(20);
    chk_out("e.t5", 16'd5, 1'b0);
    step(3);
    lap_btn = 1'b1; step(1); lap_btn = 1'b0;
`ifdef TIMER_CTRL_LAP_EN
    chk_out("e.lap_tick", 16'd5, 1'b1);
`else
    chk_out("e.lap_tick", 16'd6, 1'b0);
`endif
    step(4);
    chk_out("e.t7", 16'd7, 1'b0);
    pulse_stop();
    step(1);
    lap_btn = 1'b1; step(1); lap_btn = 1'b0;
`ifdef TIMER_CTRL_LAP_EN
    chk_out("e.lap_pause", 16'd7, 1'b1);
`else
    chk("e.lap_pause", 32'(out_valid), 32'd0);
`endif

    // clr, stop and start together in RUN: clr wins.
    pulse_start();
    step(1);
    clr_btn = 1'b1; stop_btn = 1'b1; start_btn = 1'b1;
    step(1);
    clr_btn = 1'b0; stop_btn = 1'b0; start_btn = 1'b0;
    chk("f.state", 32'(state), 32'd0);
    chk("f.valid", 32'(out_valid), 32'd0);
    chk("f.lap", 32'(out_is_lap), 32'd0);
    step(5);
    chk("f.stay_idle", 32'(state), 32'd0);
    pulse_start();
    step(4);
    chk_out("f.count0", 16'd1, 1'b0);

    // Asynchronous reset mid-run drops the pending output.
    out_ready = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    chk("g.valid", 32'(out_valid), 32'd0);
    chk("g.data", 32'(out_data), 32'd0);
    chk("g.state", 32'(state), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
